// File: rtl/satd_blk_sched.sv
// rtl/satd_blk_sched.sv - row-stream scheduler and cost accumulator for the 4x4 Hadamard SATD unit
module satd_blk_sched #(
  parameter int BLK_W   = 8,
  parameter int HAD_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BLK_W-1:0]   cur_row,
  input  logic [8*BLK_W-1:0]   ref_row,
  output logic [31:0]          had_cur0,
  output logic [31:0]          had_cur1,
  output logic [31:0]          had_cur2,
  output logic [31:0]          had_cur3,
  output logic [31:0]          had_ref0,
  output logic [31:0]          had_ref1,
  output logic [31:0]          had_ref2,
  output logic [31:0]          had_ref3,
  input  logic [15:0]          had_4x4,
  output logic                 busy,
  output logic                 satd_valid,
  output logic [23:0]          satd
);

  localparam int RW = 8 * BLK_W;
  // Column and strip counts are both BLK_W/4, so one terminal index serves both.
  localparam logic [1:0] LAST_IDX = 2'(BLK_W / 4 - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  logic [RW-1:0]        cur_buf [4];
  logic [RW-1:0]        ref_buf [4];
  logic [RW-1:0]        cur_sh  [4];
  logic [RW-1:0]        ref_sh  [4];
  logic [1:0]           row_cnt;
  logic [1:0]           col_cnt;
  logic [1:0]           strip_cnt;
  logic [HAD_LAT-1:0]   vld_sr;
  logic [HAD_LAT-1:0]   vld_sr_nxt;
  logic [23:0]          acc;
  logic [23:0]          acc_nxt;
  logic                 issue;
  logic                 row_acc;

  assign issue      = (state == ISSUE);
  assign row_acc    = in_valid & in_ready;
  assign vld_sr_nxt = (vld_sr << 1) | HAD_LAT'(issue);
  assign acc_nxt    = acc + (vld_sr[HAD_LAT-1] ? {8'd0, had_4x4} : 24'd0);

  // Left-align the selected 32-bit column so it can be taken from the top of each row.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      cur_sh[r] = cur_buf[r] << {col_cnt, 5'd0};
      ref_sh[r] = ref_buf[r] << {col_cnt, 5'd0};
    end
  end

  assign had_cur0 = issue ? cur_sh[0][RW-1 -: 32] : 32'd0;
  assign had_cur1 = issue ? cur_sh[1][RW-1 -: 32] : 32'd0;
  assign had_cur2 = issue ? cur_sh[2][RW-1 -: 32] : 32'd0;
  assign had_cur3 = issue ? cur_sh[3][RW-1 -: 32] : 32'd0;
  assign had_ref0 = issue ? ref_sh[0][RW-1 -: 32] : 32'd0;
  assign had_ref1 = issue ? ref_sh[1][RW-1 -: 32] : 32'd0;
  assign had_ref2 = issue ? ref_sh[2][RW-1 -: 32] : 32'd0;
  assign had_ref3 = issue ? ref_sh[3][RW-1 -: 32] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= 2'd0;
      col_cnt    <= 2'd0;
      strip_cnt  <= 2'd0;
      vld_sr     <= '0;
      acc        <= 24'd0;
      satd       <= 24'd0;
      satd_valid <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        cur_buf[r] <= '0;
        ref_buf[r] <= '0;
      end
    end else begin
      satd_valid <= 1'b0;
      vld_sr     <= vld_sr_nxt;
      if (state != IDLE) begin
        acc <= acc_nxt;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            acc       <= 24'd0;
            row_cnt   <= 2'd0;
            col_cnt   <= 2'd0;
            strip_cnt <= 2'd0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (row_acc) begin
            cur_buf[row_cnt] <= cur_row;
            ref_buf[row_cnt] <= ref_row;
            row_cnt          <= row_cnt + 2'd1;
            if (row_cnt == 2'd3) begin
              state    <= ISSUE;
              col_cnt  <= 2'd0;
              in_ready <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (col_cnt == LAST_IDX) begin
            col_cnt <= 2'd0;
            if (strip_cnt == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              strip_cnt <= strip_cnt + 2'd1;
              state     <= LOAD;
              in_ready  <= 1'b1;
            end
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
        end
        DRAIN: begin
          // Leave as the final return is being captured so its cost lands in satd.
          if (vld_sr_nxt == '0) begin
            state      <= DONE;
            satd       <= acc_nxt;
            satd_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
